// File: rtl/histogram_engine_pkg.sv
// Shared types for the histogram engine: FSM states, pipeline stage record
// and the bin-count helper.
package hist_pkg;

    // Widest supported bin index; stage addresses are carried at this width.
    localparam int unsigned HIST_ADDR_MAX = 16;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef logic [HIST_ADDR_MAX-1:0] hist_addr_t;

    typedef struct packed {
        logic       valid;
        hist_addr_t addr;
    } stage_t;

    function automatic int unsigned nbins(input int unsigned data_w);
        return 32'd1 << data_w;
    endfunction

endpackage

// File: rtl/histogram_engine_if.sv
// Sample stream, clear control, read-out and status bundle of the histogram
// engine; master is the sample source/reader, slave is the engine.
interface histogram_engine_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TOT_W  = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              clr_start;
    logic              busy;
    logic              rd_en;
    logic [DATA_W-1:0] rd_addr;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [TOT_W-1:0]  total;
    logic              sat_flag;
    logic [DATA_W-1:0] peak_bin;
    logic [CNT_W-1:0]  peak_cnt;

    modport master (
        output s_valid, s_data, clr_start, rd_en, rd_addr,
        input  s_ready, busy, rd_valid, rd_data, total, sat_flag, peak_bin, peak_cnt
    );

    modport slave (
        input  s_valid, s_data, clr_start, rd_en, rd_addr,
        output s_ready, busy, rd_valid, rd_data, total, sat_flag, peak_bin, peak_cnt
    );
endinterface

// File: rtl/histogram_engine_ram.sv
// Bin memory: port A reads for RMW while writing the previous update or clear,
// port B is a read-only read-out port. All reads registered, read-old-data.
module hist_ram
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] a_raddr_i,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_waddr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic [ADDR_W-1:0] b_raddr_i,
    output logic [DATA_W-1:0] b_rdata_o
);
    localparam int unsigned DEPTH = nbins(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_waddr_i] <= a_wdata_i;
        end
        a_rdata_o <= mem_q[a_raddr_i];
        b_rdata_o <= mem_q[b_raddr_i];
    end

endmodule

// File: rtl/histogram_engine.sv
// Histogram accumulator: one sample/cycle RMW with write forwarding, clear sweep,
// registered read-out, saturating bins. Define HIST_PEAK_EN to track the peak bin.
module histogram_engine
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TOT_W  = 32
) (
    input logic                CLK,
    input logic                RST,
    histogram_engine_if.slave  bus
);
    localparam logic [DATA_W-1:0] LAST_BIN = DATA_W'(nbins(DATA_W) - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] clr_addr_q, clr_addr_d;
    stage_t            s1_q, s1_d;
    logic              wr_vld_q;
    hist_addr_t        wr_addr_q;
    logic [CNT_W-1:0]  wr_data_q;
    logic [TOT_W-1:0]  total_q;
    logic              sat_q;
    logic              rd_valid_q;
    logic              rd_clr_q;

    logic              ready;
    logic              busy;
    logic              clearing;
    logic              accept;
    logic              run_wr;
    logic [CNT_W-1:0]  old_cnt;
    logic [CNT_W-1:0]  new_cnt;
    logic              ram_we;
    logic [DATA_W-1:0] ram_waddr;
    logic [CNT_W-1:0]  ram_wdata;
    logic [CNT_W-1:0]  ram_a_rdata;
    logic [CNT_W-1:0]  ram_b_rdata;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ready      = 1'b0;
        busy       = 1'b0;
        case (state_q)
            CLEAR: begin
                busy       = 1'b1;
                clr_addr_d = clr_addr_q + DATA_W'(1);
                if (clr_addr_q == LAST_BIN) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (bus.clr_start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // A clear request kills both the sample being accepted and the one in stage 1.
    always_comb begin
        clearing   = (state_d == CLEAR);
        accept     = ready && bus.s_valid;
        s1_d.valid = accept && !bus.clr_start;
        s1_d.addr  = hist_addr_t'(bus.s_data);
        old_cnt    = (wr_vld_q && (wr_addr_q == s1_q.addr)) ? wr_data_q : ram_a_rdata;
        new_cnt    = (old_cnt == CNT_MAX) ? CNT_MAX : old_cnt + CNT_W'(1);
        run_wr     = s1_q.valid && !bus.clr_start;
        ram_we     = busy || run_wr;
        ram_waddr  = busy ? clr_addr_q : s1_q.addr[DATA_W-1:0];
        ram_wdata  = busy ? '0 : new_cnt;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            s1_q       <= '0;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            total_q    <= '0;
            sat_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_clr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            s1_q       <= s1_d;
            wr_vld_q   <= run_wr;
            wr_addr_q  <= s1_q.addr;
            wr_data_q  <= new_cnt;
            if (clearing) begin
                total_q <= '0;
                sat_q   <= 1'b0;
            end else begin
                if (accept) begin
                    total_q <= total_q + TOT_W'(1);
                end
                if (run_wr && (new_cnt == CNT_MAX)) begin
                    sat_q <= 1'b1;
                end
            end
            rd_valid_q <= bus.rd_en;
            rd_clr_q   <= bus.rd_en && busy;
        end
    end

    hist_ram #(
        .ADDR_W (DATA_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk_i     (CLK),
        .a_raddr_i (bus.s_data),
        .a_rdata_o (ram_a_rdata),
        .a_we_i    (ram_we),
        .a_waddr_i (ram_waddr),
        .a_wdata_i (ram_wdata),
        .b_raddr_i (bus.rd_addr),
        .b_rdata_o (ram_b_rdata)
    );

`ifdef HIST_PEAK_EN
    logic [DATA_W-1:0] peak_bin_q;
    logic [CNT_W-1:0]  peak_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST || clearing) begin
            peak_bin_q <= '0;
            peak_cnt_q <= '0;
        end else if (run_wr && (new_cnt > peak_cnt_q)) begin
            peak_bin_q <= s1_q.addr[DATA_W-1:0];
            peak_cnt_q <= new_cnt;
        end
    end

    assign bus.peak_bin = peak_bin_q;
    assign bus.peak_cnt = peak_cnt_q;
`else
    assign bus.peak_bin = '0;
    assign bus.peak_cnt = '0;
`endif

    assign bus.s_ready  = ready;
    assign bus.busy     = busy;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = (rd_valid_q && !rd_clr_q) ? ram_b_rdata : '0;
    assign bus.total    = total_q;
    assign bus.sat_flag = sat_q;

endmodule
